// File: rtl/fifo_param_if.sv
// Producer/consumer side of the parametrised FIFO: push/pop handshake,
// data in both directions, flush and all status outputs.
interface fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  flush;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, data_in, push, pop,
        input  data_out, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  flush, data_in, push, pop,
        output data_out, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_param.sv
// Single-clock FIFO of arbitrary depth with first-word-fall-through read,
// count-based full/empty, threshold flags, sticky errors and sync flush.
module fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 2
) (
    input  logic        clock,
    input  logic        reset,
    fifo_param_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         rd_next;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_next;
    logic                  overflow_q;
    logic                  underflow_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  empty_w;
    logic                  full_w;
    logic                  push_ok;
    logic                  pop_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));
    assign pop_ok  = bus.pop & ~empty_w;
    assign push_ok = bus.push & (~full_w | bus.pop);

    always_comb begin
        rd_next    = pop_ok ? ptr_inc(rd_ptr) : rd_ptr;
        count_next = count_q;
        if (push_ok && !pop_ok)
            count_next = count_q + CW'(1);
        else if (!push_ok && pop_ok)
            count_next = count_q - CW'(1);
    end

    always_ff @(posedge clock) begin
        if (push_ok && !bus.flush)
            mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            data_q      <= '0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= ptr_inc(wr_ptr);
            rd_ptr  <= rd_next;
            count_q <= count_next;
            if (bus.push && !push_ok)
                overflow_q <= 1'b1;
            if (bus.pop && !pop_ok)
                underflow_q <= 1'b1;
            // Next head comes from the incoming word when it lands in the head slot.
            if (count_next != '0)
                data_q <= (push_ok && (wr_ptr == rd_next)) ? bus.data_in : mem[rd_next];
        end
    end

    assign bus.data_out     = data_q;
    assign bus.count        = count_q;
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_empty = (count_q <= CW'(AEMPTY_LVL));
    assign bus.almost_full  = (count_q >= CW'(AFULL_LVL));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param at DEPTH=5, AFULL_LVL=4, AEMPTY_LVL=1.
module tb_fifo_param;
    logic clock = 1'b0;
    logic reset = 1'b0;

    int checks = 0;
    int errors = 0;

    fifo_param_if #(.DATA_WIDTH(8), .DEPTH(5)) bus ();

    fifo_param #(
        .DATA_WIDTH(8),
        .DEPTH(5),
        .AFULL_LVL(4),
        .AEMPTY_LVL(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       fl, pu, po;
        logic [7:0] din;
        int         cnt;
        logic       e, f, ae, af, o, u, chk;
        logic [7:0] dat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fl, pu, po, input logic [7:0] din,
                                input int cnt, input logic e, f, ae, af, o, u, chk,
                                input logic [7:0] dat);
        vec_t v;
        v.fl = fl; v.pu = pu; v.po = po; v.din = din; v.cnt = cnt;
        v.e = e; v.f = f; v.ae = ae; v.af = af; v.o = o; v.u = u;
        v.chk = chk; v.dat = dat;
        return v;
    endfunction

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    task automatic step(input logic f, input logic p, input logic q, input logic [7:0] d);
        bus.flush   = f;
        bus.push    = p;
        bus.pop     = q;
        bus.data_in = d;
        @(posedge clock);
        #1;
    endtask

    task automatic check_status(input int id, input int cnt, input logic e, f, ae, af, o, u);
        check("count", id, 32'(bus.count), 32'(cnt));
        check("empty", id, 32'(bus.empty), 32'(e));
        check("full", id, 32'(bus.full), 32'(f));
        check("almost_empty", id, 32'(bus.almost_empty), 32'(ae));
        check("almost_full", id, 32'(bus.almost_full), 32'(af));
        check("overflow", id, 32'(bus.overflow), 32'(o));
        check("underflow", id, 32'(bus.underflow), 32'(u));
    endtask

    initial begin
        bus.flush = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;

        //                fl pu po din    cnt e  f  ae af o  u  chk dat
        vecs.push_back(mk(0, 1, 0, 8'h11, 1, 0, 0, 1, 0, 0, 0, 1, 8'h11));
        vecs.push_back(mk(0, 1, 0, 8'h12, 2, 0, 0, 0, 0, 0, 0, 1, 8'h11));
        vecs.push_back(mk(0, 1, 0, 8'h13, 3, 0, 0, 0, 0, 0, 0, 1, 8'h11));
        vecs.push_back(mk(0, 1, 0, 8'h14, 4, 0, 0, 0, 1, 0, 0, 1, 8'h11));
        vecs.push_back(mk(0, 1, 0, 8'h15, 5, 0, 1, 0, 1, 0, 0, 1, 8'h11));
        vecs.push_back(mk(0, 1, 0, 8'h16, 5, 0, 1, 0, 1, 1, 0, 1, 8'h11));
        vecs.push_back(mk(0, 0, 1, 8'h00, 4, 0, 0, 0, 1, 1, 0, 1, 8'h12));
        vecs.push_back(mk(0, 0, 1, 8'h00, 3, 0, 0, 0, 0, 1, 0, 1, 8'h13));
        vecs.push_back(mk(0, 0, 1, 8'h00, 2, 0, 0, 0, 0, 1, 0, 1, 8'h14));
        vecs.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 1, 0, 1, 0, 1, 8'h15));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 1, 0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0, 8'h00));
        // pointer wrap
        vecs.push_back(mk(0, 1, 0, 8'h01, 1, 0, 0, 1, 0, 0, 0, 1, 8'h01));
        vecs.push_back(mk(0, 1, 0, 8'h02, 2, 0, 0, 0, 0, 0, 0, 1, 8'h01));
        vecs.push_back(mk(0, 1, 0, 8'h03, 3, 0, 0, 0, 0, 0, 0, 1, 8'h01));
        vecs.push_back(mk(0, 0, 1, 8'h00, 2, 0, 0, 0, 0, 0, 0, 1, 8'h02));
        vecs.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 1, 0, 0, 0, 1, 8'h03));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'hA0, 1, 0, 0, 1, 0, 0, 0, 1, 8'hA0));
        vecs.push_back(mk(0, 1, 0, 8'hA1, 2, 0, 0, 0, 0, 0, 0, 1, 8'hA0));
        vecs.push_back(mk(0, 1, 0, 8'hA2, 3, 0, 0, 0, 0, 0, 0, 1, 8'hA0));
        vecs.push_back(mk(0, 1, 0, 8'hA3, 4, 0, 0, 0, 1, 0, 0, 1, 8'hA0));
        vecs.push_back(mk(0, 1, 0, 8'hA4, 5, 0, 1, 0, 1, 0, 0, 1, 8'hA0));
        // full + push + pop
        vecs.push_back(mk(0, 1, 1, 8'h5A, 5, 0, 1, 0, 1, 0, 0, 1, 8'hA1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 4, 0, 0, 0, 1, 0, 0, 1, 8'hA2));
        vecs.push_back(mk(0, 0, 1, 8'h00, 3, 0, 0, 0, 0, 0, 0, 1, 8'hA3));
        vecs.push_back(mk(0, 0, 1, 8'h00, 2, 0, 0, 0, 0, 0, 0, 1, 8'hA4));
        vecs.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 1, 0, 0, 0, 1, 8'h5A));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0, 8'h00));
        // empty + push + pop
        vecs.push_back(mk(0, 1, 1, 8'h33, 1, 0, 0, 1, 0, 0, 1, 1, 8'h33));
        vecs.push_back(mk(0, 1, 0, 8'h34, 2, 0, 0, 0, 0, 0, 1, 1, 8'h33));
        vecs.push_back(mk(0, 1, 0, 8'h35, 3, 0, 0, 0, 0, 0, 1, 1, 8'h33));
        vecs.push_back(mk(0, 1, 0, 8'h36, 4, 0, 0, 0, 1, 0, 1, 1, 8'h33));
        vecs.push_back(mk(0, 1, 0, 8'h37, 5, 0, 1, 0, 1, 0, 1, 1, 8'h33));
        vecs.push_back(mk(0, 1, 0, 8'h38, 5, 0, 1, 0, 1, 1, 1, 1, 8'h33));
        vecs.push_back(mk(0, 0, 1, 8'h00, 4, 0, 0, 0, 1, 1, 1, 1, 8'h34));
        vecs.push_back(mk(0, 0, 1, 8'h00, 3, 0, 0, 0, 0, 1, 1, 1, 8'h35));
        // flush wins over push+pop
        vecs.push_back(mk(1, 1, 1, 8'h99, 0, 1, 0, 1, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 1, 0, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h77, 1, 0, 0, 1, 0, 0, 1, 1, 8'h77));

        // power-on reset state
        #2;
        check_status(1000, 0, 1, 0, 1, 0, 0, 0);
        check("data_out", 1000, 32'(bus.data_out), 32'h0);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].fl, vecs[i].pu, vecs[i].po, vecs[i].din);
            check_status(i, vecs[i].cnt, vecs[i].e, vecs[i].f, vecs[i].ae, vecs[i].af,
                         vecs[i].o, vecs[i].u);
            if (vecs[i].chk)
                check("data_out", i, 32'(bus.data_out), 32'(vecs[i].dat));
        end

        // fill to full and overflow, then reset asynchronously mid-traffic
        step(0, 1, 0, 8'h78);
        step(0, 1, 0, 8'h79);
        step(0, 1, 0, 8'h7A);
        step(0, 1, 0, 8'h7B);
        step(0, 1, 0, 8'h7C);
        check_status(2000, 5, 0, 1, 0, 1, 1, 1);
        check("data_out", 2000, 32'(bus.data_out), 32'h77);
        @(negedge clock);
        bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 8'hEE;
        reset = 1'b0;
        #1;
        check_status(2001, 0, 1, 0, 1, 0, 0, 0);
        check("data_out", 2001, 32'(bus.data_out), 32'h0);
        @(posedge clock);
        #1;
        check_status(2002, 0, 1, 0, 1, 0, 0, 0);
        @(negedge clock);
        bus.push = 1'b0; bus.pop = 1'b0;
        reset = 1'b1;
        step(0, 0, 0, 8'h00);
        check_status(2003, 0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 8'h42);
        check_status(2004, 1, 0, 0, 1, 0, 0, 0);
        check("data_out", 2004, 32'(bus.data_out), 32'h42);
        step(0, 1, 0, 8'h43);
        step(0, 0, 1, 8'h00);
        check_status(2005, 1, 0, 0, 1, 0, 0, 0);
        check("data_out", 2005, 32'(bus.data_out), 32'h43);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
